// File: rtl/mux_lanes_n2m.sv
// mux_lanes_n2m: N-to-M lane multiplexer.
//
// Accepts a group of IN_LANES {valid, byte} lane words with a ready/valid
// handshake into a 2-entry group FIFO and serialises each group onto OUT_LANES
// output lanes, one phase per accepted output beat. Phase p drives out lane k
// from in lane p*OUT_LANES+k.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_data    IN_LANES lane words, lane i at [i*(DATA_W+1) +: DATA_W+1], MSB = lane valid
//   in_push    group valid
//   in_ready   FIFO has room (depends on registered occupancy only)
//   out_data   OUT_LANES lane words of the presented phase
//   out_valid  out_data holds a phase
//   out_ready  downstream accepts the phase
//   out_last   presented phase is the final one of its group
//
// Optional feature macro: MUX_IDLE_SKIP_EN -- phases whose lane-valid bits are
// all zero are never presented; an all-invalid group is dropped without output.

module mux_lanes_n2m #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IN_LANES  = 4,
    parameter int unsigned OUT_LANES = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [IN_LANES*(DATA_W+1)-1:0]   in_data,
    input  logic                             in_push,
    output logic                             in_ready,
    output logic [OUT_LANES*(DATA_W+1)-1:0]  out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last
);
    localparam int unsigned LaneW = DATA_W + 1;
    localparam int unsigned NumPh = IN_LANES / OUT_LANES;
    localparam int unsigned PhW   = (NumPh > 1) ? $clog2(NumPh) : 1;
    localparam int unsigned GrpW  = IN_LANES * LaneW;
    localparam int unsigned PhDW  = OUT_LANES * LaneW;

    if (OUT_LANES == 0 || (IN_LANES % OUT_LANES) != 0) begin : g_bad_lanes
        $error("mux_lanes_n2m: IN_LANES must be a nonzero multiple of OUT_LANES");
    end

    // State encoding doubles as FIFO occupancy (0, 1, 2 groups).
    typedef enum logic [1:0] {
        StEmpty  = 2'd0,
        StStream = 2'd1,
        StFull   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [GrpW-1:0]   mem_q [2];
    logic [GrpW-1:0]   mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [PhW-1:0]    ld_phase_q, ld_phase_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [PhDW-1:0]   out_data_q, out_data_d;

    logic              push, pop, consume, load, drop, done, pending;
    logic              ld_sel, found, has_more;
    logic [GrpW-1:0]   grp;
    logic [NumPh-1:0]  ph_valid;
    logic [PhW-1:0]    sel_ph;
    logic [PhDW-1:0]   ph_data;

    assign in_ready  = (state_q != StFull);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    // Phases of the group selected for loading that are worth presenting.
    always_comb begin
        ph_valid = '1;
`ifdef MUX_IDLE_SKIP_EN
        for (int p = 0; p < int'(NumPh); p++) begin
            ph_valid[p] = 1'b0;
            for (int k = 0; k < int'(OUT_LANES); k++) begin
                ph_valid[p] = ph_valid[p] | grp[(p * OUT_LANES + k) * LaneW + DATA_W];
            end
        end
`endif
    end

    always_comb begin
        // Once the last phase of the head group sits in the output register, the
        // head is fully loaded and loading moves on to the next entry.
        done    = out_valid_q && out_last_q;
        ld_sel  = rd_ptr_q ^ done;
        grp     = mem_q[ld_sel];
        pending = done ? (state_q == StFull) : (state_q != StEmpty);

        found  = 1'b0;
        sel_ph = '0;
        for (int p = int'(NumPh) - 1; p >= 0; p--) begin
            if (ph_valid[p] && (p >= int'(ld_phase_q))) begin
                found  = 1'b1;
                sel_ph = p[PhW-1:0];
            end
        end
        has_more = 1'b0;
        for (int p = 0; p < int'(NumPh); p++) begin
            if (ph_valid[p] && (p > int'(sel_ph))) begin
                has_more = 1'b1;
            end
        end
        ph_data = '0;
        for (int p = 0; p < int'(NumPh); p++) begin
            if (sel_ph == p[PhW-1:0]) begin
                ph_data = grp[p * PhDW +: PhDW];
            end
        end

        push    = in_push && in_ready;
        consume = out_valid_q && out_ready;
        load    = pending && found && (!out_valid_q || out_ready);
        // Only reachable with idle skipping: a pending group with nothing to show.
        drop    = pending && !found && !done;
        pop     = (consume && out_last_q) || drop;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;

        out_valid_d = out_valid_q && !out_ready;
        out_last_d  = out_last_q && !consume;
        out_data_d  = out_data_q;
        ld_phase_d  = ld_phase_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = ph_data;
            out_last_d  = !has_more;
            ld_phase_d  = has_more ? (sel_ph + PhW'(1)) : '0;
        end

        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (push) state_d = StStream;
            end
            StStream: begin
                if (push && !pop)      state_d = StFull;
                else if (pop && !push) state_d = StEmpty;
            end
            StFull: begin
                if (pop) state_d = StStream;
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StEmpty;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            ld_phase_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ld_phase_q  <= ld_phase_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
